mips_pipeline_top: RTL and testbench
====================================

// Module: mips_pipeline_top
// PURPOSE
//   5-stage (IF/ID/EX/MEM/WB) MIPS-subset pipeline with 32-bit instructions/PC and an 8-bit datapath.
//   Top level of the CPU: holds instruction ROM, 32x8 register file, main control, ALU, 256x8 data memory
//   and the four pipeline registers. Every internal stage signal is exported as an observation port.
//   Subset: R-type add/sub/and/or/slt, lw, sw, beq. No forwarding, hazard detection or flush.
//   Software inserts NOPs (0x00000000).
// PARAMETERS
//   IMEM_FILE   "imem.hex"  $readmemh image for instruction ROM (32-bit words)
//   IMEM_DEPTH  64          instruction words; indexed by pc[7:2]
//   DMEM_DEPTH  256         data bytes; indexed by 8-bit address
// PORTS
//   clk  in  1  single clock; all state updates on rising edge
//   PC_reset  in  1  reset, synchronous, active-high
//   pc_wire out 32 PC | instruction_wire out 32 ROM[pc[7:2]] | next_pc_wire out 32 pc+4
//   IF_ID_output_port out 64 {pc+4, instr}
//   RegDst_wire,Branch_wire,MemRead_wire,MemtoReg_wire,MemWrite_wire,ALUsrc_wire,RegWrite_wire out 1; ALUop_wire out 2
//     main control decoded from IF/ID opcode
//   read_data_1_wire,read_data_2_wire out 8 regfile[rs], regfile[rt]; sign_extend_wire out 32 sext(imm16)
//   ID_EX_output_port out 99 {RegDst,ALUop[1:0],ALUsrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg,
//     pc+4[31:0],rd1[7:0],rd2[7:0],sext[31:0],rt[4:0],rd[4:0]}
//   ID_EX_branch_wire out 1; ID_EX_PC_value out 32 pc+4 in EX; left_shift_wire out 32 ID/EX sext<<2
//   ALU_op_2 out 8 ALUsrc ? sext[7:0] : rd2; ALU_control_signal_wire out 4
//   ALU_result_wire out 8; zero_wire out 1 (result==0); rt_rd_reg_address_mux_out out 5 RegDst ? rd : rt
//   target_pc_wire out 32 ID_EX_PC_value + left_shift_wire
//   EX_MEM_output_port out 59 {Branch,MemRead,MemWrite,RegWrite,MemtoReg,target[31:0],zero,alu[7:0],rd2[7:0],dst[4:0]}
//   PC_value_after_EX_MEM out 32 target in MEM; PCSrc out 1 EX/MEM Branch & zero
//   data_mem_MemRead_signal out 1; data_mem_write_addr,data_mem_write_data out 8 EX/MEM alu, rd2
//   data_mem_dout_wire out 8 MemRead ? dmem[addr] : 0
//   selected_address_for_pc out 32 PCSrc ? PC_value_after_EX_MEM : next_pc_wire
//   MEM_WB_output_port out 23 {RegWrite,MemtoReg,dout[7:0],alu[7:0],dst[4:0]}
//   write_back_data_wire out 8 MemtoReg ? dout : alu; regfile_write_reg_address out 5 MEM/WB dst
// BEHAVIOUR
//   Reset (clk edge with PC_reset=1): PC=0; IF/ID, ID/EX, EX/MEM, MEM/WB=0; regfile[i]=i; dmem[i]=i.
//     Then pc_wire=0, all control outputs 0, PCSrc=0. Reset mid-run discards all in-flight instrs.
//   Each edge: PC<=selected_address_for_pc; each pipeline reg latches the previous stage. One instr/cycle.
//   Latency: an instr fetched at edge N writes back at edge N+4.
//   Control (opcode): 000000 R: RegDst,RegWrite, ALUop=10; 100011 lw: ALUsrc,MemRead,MemtoReg,RegWrite, ALUop=00;
//     101011 sw: ALUsrc,MemWrite, ALUop=00; 000100 beq: Branch, ALUop=01; other opcodes: all 0.
//   ALU control: ALUop 00->0010 add; 01->0110 sub; 10 by funct: 100000 0010, 100010 0110,
//     100100 0000 and, 100101 0001 or, 101010 0111 slt (signed 8-bit, result 1/0); unknown funct -> 0010.
//   ALU arithmetic mod 2^8. Data address = alu[7:0]. dmem write on edge when EX/MEM MemWrite.
//   Regfile: reads combinational; write on edge when MEM/WB RegWrite and dst!=0; r0 reads 0 always.
//     Same-cycle write/read of one reg returns the new value (write-through).
//   beq resolves in MEM: instrs fetched in the 3 following slots are not flushed and complete.
// TESTING
//   1 Reset: PC_reset=1 one edge -> pc_wire=0, next_pc_wire=4, all pipeline ports 0; next edges pc 4,8,12.
//   2 add $3,$1,$2 (0x00221820) -> ALU_result=3 in EX; 4 edges after fetch write_back_data=3,
//     regfile_write_reg_address=3.
//   3 lw $4,5($0) (0x8C040005) -> data_mem_dout=5 in MEM; WB writes 5 to r4.
//   4 sw $2,7($0) (0xAC020007) + 3 NOPs + lw $5,7($0) -> r5=2; r0 never changes.
//   5 beq $1,$1,+2 (0x10210002) at pc 0 -> zero=1, PCSrc=1 in MEM, target=0x0C; PC loads 0x0C next edge.
//     beq $1,$2 -> PCSrc=0.
//   6 sub/and/or/slt on r5,r3 -> 2,1,7,0; assert reset mid-program -> PC=0, in-flight writes suppressed.

Source files
------------

// File: rtl/mips_pipeline_top.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB), 32-bit instructions, 8-bit datapath.
// No forwarding, hazard detection or flush: software pads dependencies and branch shadows with NOPs.
module mips_pipeline_top #(
  parameter string IMEM_FILE  = "imem.hex",
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        PC_reset,
  output logic [31:0] pc_wire,
  output logic [31:0] instruction_wire,
  output logic [31:0] next_pc_wire,
  output logic [63:0] IF_ID_output_port,
  output logic        RegDst_wire,
  output logic        Branch_wire,
  output logic        MemRead_wire,
  output logic        MemtoReg_wire,
  output logic        MemWrite_wire,
  output logic        ALUsrc_wire,
  output logic        RegWrite_wire,
  output logic [1:0]  ALUop_wire,
  output logic [7:0]  read_data_1_wire,
  output logic [7:0]  read_data_2_wire,
  output logic [31:0] sign_extend_wire,
  output logic [98:0] ID_EX_output_port,
  output logic        ID_EX_branch_wire,
  output logic [31:0] ID_EX_PC_value,
  output logic [31:0] left_shift_wire,
  output logic [7:0]  ALU_op_2,
  output logic [3:0]  ALU_control_signal_wire,
  output logic [7:0]  ALU_result_wire,
  output logic        zero_wire,
  output logic [4:0]  rt_rd_reg_address_mux_out,
  output logic [31:0] target_pc_wire,
  output logic [58:0] EX_MEM_output_port,
  output logic [31:0] PC_value_after_EX_MEM,
  output logic        PCSrc,
  output logic        data_mem_MemRead_signal,
  output logic [7:0]  data_mem_write_addr,
  output logic [7:0]  data_mem_write_data,
  output logic [7:0]  data_mem_dout_wire,
  output logic [31:0] selected_address_for_pc,
  output logic [22:0] MEM_WB_output_port,
  output logic [7:0]  write_back_data_wire,
  output logic [4:0]  regfile_write_reg_address
);
  localparam int IW = $clog2(IMEM_DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] pc4;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] target;
    logic        zero;
    logic [7:0]  alu;
    logic [7:0]  rd2;
    logic [4:0]  dst;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [7:0] dout;
    logic [7:0] alu;
    logic [4:0] dst;
  } mem_wb_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [7:0]  rf   [32];
  logic [7:0]  dmem [DMEM_DEPTH];
  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        wb_en;

  // IF
  assign pc_wire           = pc;
  assign instruction_wire  = imem[pc[IW+1:2]];
  assign next_pc_wire      = pc + 32'd4;
  assign IF_ID_output_port = if_id;

  // ID: an all-zero word is a true NOP so it raises no control at all
  assign opcode = if_id.instr[31:26];
  assign rs     = if_id.instr[25:21];
  assign rt     = if_id.instr[20:16];
  assign rd     = if_id.instr[15:11];

  always_comb begin
    RegDst_wire   = 1'b0;
    Branch_wire   = 1'b0;
    MemRead_wire  = 1'b0;
    MemtoReg_wire = 1'b0;
    MemWrite_wire = 1'b0;
    ALUsrc_wire   = 1'b0;
    RegWrite_wire = 1'b0;
    ALUop_wire    = 2'b00;
    if (if_id.instr != 32'd0) begin
      case (opcode)
        6'b000000: begin RegDst_wire = 1'b1; RegWrite_wire = 1'b1; ALUop_wire = 2'b10; end
        6'b100011: begin
          ALUsrc_wire = 1'b1; MemRead_wire = 1'b1; MemtoReg_wire = 1'b1; RegWrite_wire = 1'b1;
        end
        6'b101011: begin ALUsrc_wire = 1'b1; MemWrite_wire = 1'b1; end
        6'b000100: begin Branch_wire = 1'b1; ALUop_wire = 2'b01; end
        default: ;
      endcase
    end
  end

  // Write-through: a register being written back this cycle is read with its new value
  assign wb_en                = mem_wb.reg_write && (mem_wb.dst != 5'd0);
  assign write_back_data_wire = mem_wb.mem_to_reg ? mem_wb.dout : mem_wb.alu;
  assign read_data_1_wire     = (rs == 5'd0) ? 8'd0 :
                                (wb_en && mem_wb.dst == rs) ? write_back_data_wire : rf[rs];
  assign read_data_2_wire     = (rt == 5'd0) ? 8'd0 :
                                (wb_en && mem_wb.dst == rt) ? write_back_data_wire : rf[rt];
  assign sign_extend_wire     = {{16{if_id.instr[15]}}, if_id.instr[15:0]};

  // EX
  assign ID_EX_output_port         = id_ex;
  assign ID_EX_branch_wire         = id_ex.branch;
  assign ID_EX_PC_value            = id_ex.pc4;
  assign left_shift_wire           = {id_ex.sext[29:0], 2'b00};
  assign target_pc_wire            = id_ex.pc4 + left_shift_wire;
  assign ALU_op_2                  = id_ex.alu_src ? id_ex.sext[7:0] : id_ex.rd2;
  assign rt_rd_reg_address_mux_out = id_ex.reg_dst ? id_ex.rd : id_ex.rt;
  assign zero_wire                 = (ALU_result_wire == 8'd0);

  always_comb begin
    ALU_control_signal_wire = 4'b0010;
    case (id_ex.alu_op)
      2'b01: ALU_control_signal_wire = 4'b0110;
      2'b10: begin
        case (id_ex.sext[5:0])
          6'b100010: ALU_control_signal_wire = 4'b0110;
          6'b100100: ALU_control_signal_wire = 4'b0000;
          6'b100101: ALU_control_signal_wire = 4'b0001;
          6'b101010: ALU_control_signal_wire = 4'b0111;
          default:   ALU_control_signal_wire = 4'b0010;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    ALU_result_wire = id_ex.rd1 + ALU_op_2;
    case (ALU_control_signal_wire)
      4'b0110: ALU_result_wire = id_ex.rd1 - ALU_op_2;
      4'b0000: ALU_result_wire = id_ex.rd1 & ALU_op_2;
      4'b0001: ALU_result_wire = id_ex.rd1 | ALU_op_2;
      4'b0111: ALU_result_wire = {7'd0, ($signed(id_ex.rd1) < $signed(ALU_op_2))};
      default: ;
    endcase
  end

  // MEM: branch resolves here, so the three following fetches always complete
  assign EX_MEM_output_port      = ex_mem;
  assign PC_value_after_EX_MEM   = ex_mem.target;
  assign PCSrc                   = ex_mem.branch & ex_mem.zero;
  assign data_mem_MemRead_signal = ex_mem.mem_read;
  assign data_mem_write_addr     = ex_mem.alu;
  assign data_mem_write_data     = ex_mem.rd2;
  assign data_mem_dout_wire      = ex_mem.mem_read ? dmem[ex_mem.alu] : 8'd0;
  assign selected_address_for_pc = PCSrc ? PC_value_after_EX_MEM : next_pc_wire;

  // WB
  assign MEM_WB_output_port        = mem_wb;
  assign regfile_write_reg_address = mem_wb.dst;

  always_ff @(posedge clk) begin
    if (PC_reset) begin
      pc     <= 32'd0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      pc     <= selected_address_for_pc;
      if_id  <= '{pc4: next_pc_wire, instr: instruction_wire};
      id_ex  <= '{reg_dst: RegDst_wire, alu_op: ALUop_wire, alu_src: ALUsrc_wire,
                  branch: Branch_wire, mem_read: MemRead_wire, mem_write: MemWrite_wire,
                  reg_write: RegWrite_wire, mem_to_reg: MemtoReg_wire, pc4: if_id.pc4,
                  rd1: read_data_1_wire, rd2: read_data_2_wire, sext: sign_extend_wire,
                  rt: rt, rd: rd};
      ex_mem <= '{branch: id_ex.branch, mem_read: id_ex.mem_read, mem_write: id_ex.mem_write,
                  reg_write: id_ex.reg_write, mem_to_reg: id_ex.mem_to_reg,
                  target: target_pc_wire, zero: zero_wire, alu: ALU_result_wire,
                  rd2: id_ex.rd2, dst: rt_rd_reg_address_mux_out};
      mem_wb <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg,
                  dout: data_mem_dout_wire, alu: ex_mem.alu, dst: ex_mem.dst};
    end
  end

  always_ff @(posedge clk) begin
    if (PC_reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'(i);
    end else if (wb_en) begin
      rf[mem_wb.dst] <= write_back_data_wire;
    end
  end

  always_ff @(posedge clk) begin
    if (PC_reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 8'(i);
    end else if (ex_mem.mem_write) begin
      dmem[ex_mem.alu] <= ex_mem.rd2;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_top.sv
// Directed bench for mips_pipeline_top: two small programs, write-back scoreboard and per-stage probes.
module tb_mips_pipeline_top;
  logic        clk;
  logic        PC_reset;
  logic [31:0] pc_wire, instruction_wire, next_pc_wire;
  logic [63:0] IF_ID_output_port;
  logic        RegDst_wire, Branch_wire, MemRead_wire, MemtoReg_wire, MemWrite_wire;
  logic        ALUsrc_wire, RegWrite_wire;
  logic [1:0]  ALUop_wire;
  logic [7:0]  read_data_1_wire, read_data_2_wire;
  logic [31:0] sign_extend_wire;
  logic [98:0] ID_EX_output_port;
  logic        ID_EX_branch_wire;
  logic [31:0] ID_EX_PC_value, left_shift_wire;
  logic [7:0]  ALU_op_2;
  logic [3:0]  ALU_control_signal_wire;
  logic [7:0]  ALU_result_wire;
  logic        zero_wire;
  logic [4:0]  rt_rd_reg_address_mux_out;
  logic [31:0] target_pc_wire;
  logic [58:0] EX_MEM_output_port;
  logic [31:0] PC_value_after_EX_MEM;
  logic        PCSrc, data_mem_MemRead_signal;
  logic [7:0]  data_mem_write_addr, data_mem_write_data, data_mem_dout_wire;
  logic [31:0] selected_address_for_pc;
  logic [22:0] MEM_WB_output_port;
  logic [7:0]  write_back_data_wire;
  logic [4:0]  regfile_write_reg_address;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  mips_pipeline_top #(.IMEM_FILE(""), .IMEM_DEPTH(64), .DMEM_DEPTH(256)) dut (
    .clk(clk), .PC_reset(PC_reset),
    .pc_wire(pc_wire), .instruction_wire(instruction_wire), .next_pc_wire(next_pc_wire),
    .IF_ID_output_port(IF_ID_output_port),
    .RegDst_wire(RegDst_wire), .Branch_wire(Branch_wire), .MemRead_wire(MemRead_wire),
    .MemtoReg_wire(MemtoReg_wire), .MemWrite_wire(MemWrite_wire), .ALUsrc_wire(ALUsrc_wire),
    .RegWrite_wire(RegWrite_wire), .ALUop_wire(ALUop_wire),
    .read_data_1_wire(read_data_1_wire), .read_data_2_wire(read_data_2_wire),
    .sign_extend_wire(sign_extend_wire), .ID_EX_output_port(ID_EX_output_port),
    .ID_EX_branch_wire(ID_EX_branch_wire), .ID_EX_PC_value(ID_EX_PC_value),
    .left_shift_wire(left_shift_wire), .ALU_op_2(ALU_op_2),
    .ALU_control_signal_wire(ALU_control_signal_wire), .ALU_result_wire(ALU_result_wire),
    .zero_wire(zero_wire), .rt_rd_reg_address_mux_out(rt_rd_reg_address_mux_out),
    .target_pc_wire(target_pc_wire), .EX_MEM_output_port(EX_MEM_output_port),
    .PC_value_after_EX_MEM(PC_value_after_EX_MEM), .PCSrc(PCSrc),
    .data_mem_MemRead_signal(data_mem_MemRead_signal),
    .data_mem_write_addr(data_mem_write_addr), .data_mem_write_data(data_mem_write_data),
    .data_mem_dout_wire(data_mem_dout_wire), .selected_address_for_pc(selected_address_for_pc),
    .MEM_WB_output_port(MEM_WB_output_port), .write_back_data_wire(write_back_data_wire),
    .regfile_write_reg_address(regfile_write_reg_address)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [98:0] obs, input logic [98:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] prog[$]);
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
  endtask

  task automatic push_wb(input logic [4:0] dst, input logic [7:0] data);
    exp_q.push_back({dst, data});
  endtask

  // scoreboard: every register write-back (dst != 0) must match the next expected entry
  always @(negedge clk) begin
    if (!PC_reset && MEM_WB_output_port[22] && regfile_write_reg_address != 5'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wb_unexpected: observed %0h expected none",
               {regfile_write_reg_address, write_back_data_wire});
      end else begin
        check("wb", {regfile_write_reg_address, write_back_data_wire}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] prog_a[$];
    logic [31:0] prog_b[$];
    prog_a = '{32'h00221820, 32'h8C040005, 32'hAC020007, 32'h00633020, 32'h0, 32'h0,
               32'h8C050007, 32'h00220020, 32'h0, 32'h0, 32'h0, 32'h00013820,
               32'h10220002, 32'h10210004, 32'h00214020, 32'h0, 32'h0, 32'h00425020,
               32'h00225820};
    prog_b = '{32'h00A36022, 32'h00A36824, 32'h00A37025, 32'h00A3782A, 32'h0065802A,
               32'h00228822, 32'h0, 32'h0, 32'h0221902A, 32'h00229800, 32'h0021A020,
               32'h0021A820};

    // reset state
    PC_reset = 1'b1;
    load_prog(prog_a);
    step();
    check("rst_pc", pc_wire, 0);
    check("rst_next_pc", next_pc_wire, 4);
    check("rst_if_id", IF_ID_output_port, 0);
    check("rst_id_ex", ID_EX_output_port, 0);
    check("rst_ex_mem", EX_MEM_output_port, 0);
    check("rst_mem_wb", MEM_WB_output_port, 0);
    check("rst_ctrl", {RegDst_wire, Branch_wire, MemRead_wire, MemtoReg_wire, MemWrite_wire,
                       ALUsrc_wire, RegWrite_wire, ALUop_wire}, 0);
    check("rst_pcsrc", PCSrc, 0);

    // program A: add, lw, sw->lw, r0 protection, beq not-taken and taken
    push_wb(5'd3, 8'd3);
    push_wb(5'd4, 8'd5);
    push_wb(5'd6, 8'd6);
    push_wb(5'd5, 8'd2);
    push_wb(5'd7, 8'd1);
    push_wb(5'd8, 8'd2);
    push_wb(5'd11, 8'd3);
    PC_reset = 1'b0;

    step(); // edge 1
    check("pc_e1", pc_wire, 4);
    check("if_id_add", IF_ID_output_port, {32'd4, 32'h00221820});
    check("ctrl_r", {RegDst_wire, RegWrite_wire, ALUop_wire, MemRead_wire, ALUsrc_wire}, 6'b111000);
    check("rd_regs_add", {read_data_1_wire, read_data_2_wire}, {8'd1, 8'd2});
    step(); // edge 2
    check("pc_e2", pc_wire, 8);
    check("alu_add", ALU_result_wire, 3);
    check("aluctl_add", ALU_control_signal_wire, 4'b0010);
    check("dst_add", rt_rd_reg_address_mux_out, 3);
    check("ctrl_lw", {MemRead_wire, MemtoReg_wire, ALUsrc_wire, RegWrite_wire, RegDst_wire, ALUop_wire},
          7'b1111000);
    check("sext_lw", sign_extend_wire, 5);
    step(); // edge 3
    check("pc_e3", pc_wire, 12);
    check("alu_op2_lw", ALU_op_2, 5);
    check("dst_lw", rt_rd_reg_address_mux_out, 4);
    step(); // edge 4
    check("dout_lw", data_mem_dout_wire, 5);
    check("memread_lw", data_mem_MemRead_signal, 1);
    check("wb_add", {regfile_write_reg_address, write_back_data_wire}, {5'd3, 8'd3});
    step(); // edge 5
    check("sw_addr", data_mem_write_addr, 7);
    check("sw_data", data_mem_write_data, 2);
    check("sw_dout", data_mem_dout_wire, 0);
    for (int e = 6; e <= 14; e++) step();
    check("ctrl_beq", {Branch_wire, ALUop_wire, RegWrite_wire}, 4'b1010);
    step(); // edge 15
    check("pcsrc_not_taken", PCSrc, 0);
    check("id_ex_branch", ID_EX_branch_wire, 1);
    check("id_ex_pc", ID_EX_PC_value, 56);
    check("left_shift", left_shift_wire, 16);
    check("target", target_pc_wire, 72);
    check("zero_beq", zero_wire, 1);
    step(); // edge 16
    check("pcsrc_taken", PCSrc, 1);
    check("pc_after_ex_mem", PC_value_after_EX_MEM, 72);
    check("selected_pc", selected_address_for_pc, 72);
    check("pc_e16", pc_wire, 64);
    step(); // edge 17
    check("pc_branch_load", pc_wire, 72);
    for (int e = 18; e <= 23; e++) step();
    check("drain_a", exp_q.size(), 0);

    // program B: ALU ops, signed slt, default funct, reset mid-run
    PC_reset = 1'b1;
    load_prog(prog_b);
    step();
    PC_reset = 1'b0;
    push_wb(5'd12, 8'd2);
    push_wb(5'd13, 8'd1);
    push_wb(5'd14, 8'd7);
    push_wb(5'd15, 8'd0);
    push_wb(5'd16, 8'd1);
    push_wb(5'd17, 8'hFF);
    push_wb(5'd18, 8'd1);
    push_wb(5'd19, 8'd3);
    for (int e = 1; e <= 5; e++) step();
    check("aluctl_slt", ALU_control_signal_wire, 4'b0111);
    check("alu_slt", ALU_result_wire, 0);
    for (int e = 6; e <= 11; e++) step();
    check("aluctl_default", ALU_control_signal_wire, 4'b0010);
    check("alu_default", ALU_result_wire, 3);
    for (int e = 12; e <= 14; e++) step();
    PC_reset = 1'b1; // add $20 and add $21 still in flight are discarded
    step();
    check("mid_rst_pc", pc_wire, 0);
    check("mid_rst_if_id", IF_ID_output_port, 0);
    check("mid_rst_id_ex", ID_EX_output_port, 0);
    check("mid_rst_ex_mem", EX_MEM_output_port, 0);
    check("mid_rst_mem_wb", MEM_WB_output_port, 0);
    check("mid_rst_pcsrc", PCSrc, 0);
    check("drain_b", exp_q.size(), 0);
    PC_reset = 1'b0;
    push_wb(5'd12, 8'd2);
    push_wb(5'd13, 8'd1);
    for (int e = 1; e <= 5; e++) step();
    @(negedge clk);
    #1;
    check("drain_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
